dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Two-master arbiter for the single-ported data memory (DM). Master 0 is the CPU
//  MEM stage; master 1 is a loader/debug port. One access per cycle: writes commit
//  at the clock edge, reads return registered data one cycle later. Each master
//  gets a req/ack handshake and an error flag.
// PARAMETERS
//  ARB_MODE   1     0 = round robin; 1 = m0 priority with starvation guard
//  MAX_WAIT   4     ARB_MODE=1: max consecutive m0 grants while m1 waits (1..15)
//  ADDR_WORDS 1024  DM depth in words; valid byte address range [0, 4*ADDR_WORDS)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  m0_req       in   1   m0 access request; hold fields stable until m0_ack
//  m0_we        in   1   1 = write, 0 = read
//  m0_addr      in   32  byte address
//  m0_wdata     in   32  write data
//  m0_pc        in   32  PC of the issuing instruction, forwarded to DM
//  m0_ack       out  1   comb.: request granted and performed this cycle
//  m0_rvalid    out  1   registered: m0_rdata valid for the read acked last cycle
//  m0_rdata     out  32  registered read data
//  m0_err       out  1   registered: access acked last cycle was out of range or misaligned
//  m1_*         --   --  same set of signals as m0_*, for master 1
//  dm_daddr     out  32  address to DM
//  dm_din       out  32  write data to DM
//  dm_pc        out  32  PC to DM
//  dm_memwrite  out  1   DM write enable
//  dm_dout      in   32  DM combinational read data
//  grant_id     out  1   comb.: master owning DM this cycle (valid when ack high)
// BEHAVIOUR
//  - Reset: last_grant=1 (so m0 wins first RR tie), wait_cnt=0. All registered
//    outputs (mX_rvalid, mX_rdata, mX_err) are 0. While reset is high: mX_ack=0 and
//    dm_memwrite=0. A request present in the reset cycle is not acked. Reads acked
//    before reset never produce rvalid.
//  - Grant, combinational in cycle t:
//    - Only one master requesting: that master wins.
//    - Both requesting, RR mode: the master != last_grant wins.
//    - Both requesting, mode 1: m0 wins unless wait_cnt==MAX_WAIT, then m1 wins.
//  - The winner gets mX_ack=1 in cycle t, and its addr/wdata/pc drive dm_*.
//    The loser's ack is 0 and it must hold its request. No grant: dm_* = m0 fields,
//    dm_memwrite=0.
//  - Legality: legal iff addr[1:0]==0 and addr < 4*ADDR_WORDS.
//    - Illegal access: acked, dm_memwrite forced 0. Next cycle mX_err=1; if it was
//      a read, rvalid=1 and rdata=0.
//  - Write: dm_memwrite = ack & we & legal. Data is written at the posedge ending
//    cycle t. No rvalid.
//  - Read: at posedge ending t, mX_rdata<=dm_dout and mX_rvalid<=1.
//    - Latency is 1 cycle from ack to rvalid.
//    - rvalid, err and rdata hold only one cycle; rdata keeps its value otherwise.
//  - A read in cycle t+1 sees a write from cycle t at the same address (write-then-read).
//  - last_grant updates to the winner on every grant and is unchanged on idle cycles.
//  - wait_cnt:
//    - +1 when m0 is granted and m1_req=1, saturating at MAX_WAIT.
//    - Cleared when m1 is granted or m1_req=0.
//  - Back-to-back: a master may re-request in cycle t+1 with new fields after an ack.
//  - A master dropping req before ack is legal; that request is discarded with no
//    side effects.
// TESTING
//  T1 m0 write 0x10<=0xDEADBEEF, then m0 read 0x10:
//     -> ack in both cycles; m0_rvalid=1 with 0xDEADBEEF one cycle after the read ack.
//  T2 ARB_MODE=0, both request every cycle for 6 cycles:
//     -> acks alternate m0,m1,m0,m1,m0,m1; no cycle has both acks.
//  T3 ARB_MODE=1, MAX_WAIT=4, both request continuously:
//     -> grant pattern m0 x4, m1, m0 x4, m1; wait_cnt resets after each m1 grant.
//  T4 m1 write to 0x1000, then m1 read from 0x2:
//     -> both acked; dm_memwrite stays 0; m1_err=1 after each;
//        the read returns rvalid=1 with rdata=0.
//  T5 m0 read acked in cycle t, reset asserted in cycle t+1:
//     -> m0_rvalid=0 in t+1 and t+2; no ack while reset is high;
//        the first grant after reset goes to m0.
//  T6 m0 write 0x20<=5 in cycle t, m1 read 0x20 in cycle t+1:
//     -> m1_rdata=5 with m1_rvalid=1 at t+2; a scoreboard matches every DM write.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Two-master arbiter in front of the single-ported data memory. Master 0 is the
// CPU MEM stage, master 1 is the loader/debug port. At most one access reaches
// the memory per cycle. Writes commit at the clock edge that ends the granted
// cycle. Reads return registered data in the next cycle. Out-of-range or
// misaligned accesses are still acknowledged, but the memory is not written and
// the master sees an error flag (plus zero read data for reads) one cycle later.
module dm_port_arbiter #(
  parameter int ARB_MODE   = 1,    // 0: round robin, 1: m0 priority with starvation guard
  parameter int MAX_WAIT   = 4,    // consecutive m0 grants tolerated while m1 waits (1..15)
  parameter int ADDR_WORDS = 1024  // memory depth in 32-bit words
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_pc,
  output logic        m0_ack,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_pc,
  output logic        m1_ack,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic [31:0] dm_daddr,
  output logic [31:0] dm_din,
  output logic [31:0] dm_pc,
  output logic        dm_memwrite,
  input  logic [31:0] dm_dout,

  output logic        grant_id
);

  // Exclusive upper bound of the legal byte address range, one bit wider than
  // the address so that a 4 GiB memory would still compare correctly.
  localparam logic [32:0] ADDR_LIMIT_C = 33'(ADDR_WORDS) << 2;
  localparam logic [3:0]  MAX_WAIT_C   = 4'(MAX_WAIT);

  // Word-aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < ADDR_LIMIT_C);
  endfunction

  logic        last_grant_r;   // master granted most recently (1 = m1)
  logic [3:0]  wait_cnt_r;     // m0 grants in a row while m1 was waiting

  logic        grant_any_s;    // some master owns the memory this cycle
  logic        grant_m1_s;     // owner is m1 (meaningful only with grant_any_s)
  logic        sel_we_s;
  logic [31:0] sel_addr_s;

  logic        m0_legal_s;
  logic        m1_legal_s;
  logic        m0_rd_s;
  logic        m1_rd_s;

  logic        m0_rvalid_r;
  logic        m0_err_r;
  logic [31:0] m0_rdata_r;
  logic        m1_rvalid_r;
  logic        m1_err_r;
  logic [31:0] m1_rdata_r;

  // Arbitration: pick the winner for this cycle; nothing is granted in reset.
  always_comb begin
    grant_any_s = 1'b0;
    grant_m1_s  = 1'b0;
    if (reset) begin
      grant_any_s = 1'b0;
      grant_m1_s  = 1'b0;
    end else if (m0_req && m1_req) begin
      grant_any_s = 1'b1;
      if (ARB_MODE == 0) begin
        // Round robin: whoever did not win last time.
        grant_m1_s = ~last_grant_r;
      end else begin
        // m0 priority, unless m1 has already waited MAX_WAIT grants.
        grant_m1_s = (wait_cnt_r == MAX_WAIT_C);
      end
    end else if (m0_req) begin
      grant_any_s = 1'b1;
      grant_m1_s  = 1'b0;
    end else if (m1_req) begin
      grant_any_s = 1'b1;
      grant_m1_s  = 1'b1;
    end else begin
      grant_any_s = 1'b0;
      grant_m1_s  = 1'b0;
    end
  end

  // Memory-side mux: the owner's fields go to DM; m0 fields when idle.
  always_comb begin
    sel_we_s   = m0_we;
    sel_addr_s = m0_addr;
    dm_din     = m0_wdata;
    dm_pc      = m0_pc;
    if (grant_any_s && grant_m1_s) begin
      sel_we_s   = m1_we;
      sel_addr_s = m1_addr;
      dm_din     = m1_wdata;
      dm_pc      = m1_pc;
    end else begin
      sel_we_s   = m0_we;
      sel_addr_s = m0_addr;
      dm_din     = m0_wdata;
      dm_pc      = m0_pc;
    end
  end

  assign dm_daddr    = sel_addr_s;
  assign dm_memwrite = grant_any_s & sel_we_s & addr_legal(sel_addr_s);

  assign m0_ack   = grant_any_s & ~grant_m1_s;
  assign m1_ack   = grant_any_s &  grant_m1_s;
  assign grant_id = grant_m1_s;

  assign m0_legal_s = addr_legal(m0_addr);
  assign m1_legal_s = addr_legal(m1_addr);
  assign m0_rd_s    = m0_ack & ~m0_we;
  assign m1_rd_s    = m1_ack & ~m1_we;

  // Remember the last winner; idle cycles leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (grant_any_s) begin
      last_grant_r <= grant_m1_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Starvation guard: count m0 wins while m1 is waiting, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 4'd0;
    end else if (m0_ack && m1_req) begin
      if (wait_cnt_r == MAX_WAIT_C) begin
        wait_cnt_r <= wait_cnt_r;
      end else begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end
    end else if (m1_ack || !m1_req) begin
      wait_cnt_r <= 4'd0;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // m0 response: one-cycle rvalid/err pulses, rdata held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid_r <= 1'b0;
      m0_err_r    <= 1'b0;
      m0_rdata_r  <= 32'h0000_0000;
    end else begin
      m0_rvalid_r <= m0_rd_s;
      m0_err_r    <= m0_ack & ~m0_legal_s;
      if (m0_rd_s) begin
        m0_rdata_r <= m0_legal_s ? dm_dout : 32'h0000_0000;
      end else begin
        m0_rdata_r <= m0_rdata_r;
      end
    end
  end

  // m1 response: one-cycle rvalid/err pulses, rdata held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      m1_rvalid_r <= 1'b0;
      m1_err_r    <= 1'b0;
      m1_rdata_r  <= 32'h0000_0000;
    end else begin
      m1_rvalid_r <= m1_rd_s;
      m1_err_r    <= m1_ack & ~m1_legal_s;
      if (m1_rd_s) begin
        m1_rdata_r <= m1_legal_s ? dm_dout : 32'h0000_0000;
      end else begin
        m1_rdata_r <= m1_rdata_r;
      end
    end
  end

  // A read acked in the cycle just before reset would otherwise surface while
  // reset is already high; masking the registered responses with reset keeps
  // every response quiet for the whole reset period.
  assign m0_rvalid = m0_rvalid_r & ~reset;
  assign m0_err    = m0_err_r    & ~reset;
  assign m0_rdata  = reset ? 32'h0000_0000 : m0_rdata_r;
  assign m1_rvalid = m1_rvalid_r & ~reset;
  assign m1_err    = m1_err_r    & ~reset;
  assign m1_rdata  = reset ? 32'h0000_0000 : m1_rdata_r;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
// Directed bench: one arbiter in priority mode (MAX_WAIT=4) attached to a
// behavioural data memory with a write scoreboard, plus a second arbiter in
// round-robin mode for the alternating-grant case.
module tb_dm_port_arbiter;

  logic        clk;
  logic        reset;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc;
  logic        m0_ack, m0_rvalid, m0_err, m1_ack, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dm_daddr, dm_din, dm_pc, dm_dout;
  logic        dm_memwrite, grant_id;

  logic        rr_m0_req, rr_m1_req;
  logic        rr_m0_ack, rr_m0_rvalid, rr_m0_err, rr_m1_ack, rr_m1_rvalid, rr_m1_err;
  logic [31:0] rr_m0_rdata, rr_m1_rdata;
  logic [31:0] rr_daddr, rr_din, rr_pc;
  logic        rr_memwrite, rr_grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];

  dm_port_arbiter #(.ARB_MODE(1), .MAX_WAIT(4), .ADDR_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_daddr(dm_daddr), .dm_din(dm_din), .dm_pc(dm_pc), .dm_memwrite(dm_memwrite),
    .dm_dout(dm_dout), .grant_id(grant_id)
  );

  dm_port_arbiter #(.ARB_MODE(0), .MAX_WAIT(4), .ADDR_WORDS(1024)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_req(rr_m0_req), .m0_we(1'b0), .m0_addr(32'h0000_0000), .m0_wdata(32'h0000_0000),
    .m0_pc(32'h0000_0000),
    .m0_ack(rr_m0_ack), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata), .m0_err(rr_m0_err),
    .m1_req(rr_m1_req), .m1_we(1'b0), .m1_addr(32'h0000_0004), .m1_wdata(32'h0000_0000),
    .m1_pc(32'h0000_0000),
    .m1_ack(rr_m1_ack), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata), .m1_err(rr_m1_err),
    .dm_daddr(rr_daddr), .dm_din(rr_din), .dm_pc(rr_pc), .dm_memwrite(rr_memwrite),
    .dm_dout(32'h0000_0000), .grant_id(rr_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the clock edge.
  assign dm_dout = mem[dm_daddr[11:2]];
  always @(posedge clk) begin
    if (dm_memwrite) mem[dm_daddr[11:2]] <= dm_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every DM write must match the next expected write.
  always @(negedge clk) begin
    if (dm_memwrite) begin
      if (wq_addr.size() == 0) begin
        check("sb_unexpected_write", 32'(dm_memwrite), 32'd0);
      end else begin
        check("sb_addr", dm_daddr, wq_addr.pop_front());
        check("sb_data", dm_din, wq_data.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic drv0(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    m0_pc = 32'h0040_0000 + addr;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    m1_pc = 32'h0080_0000 + addr;
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wq_addr.push_back(addr);
    wq_data.push_back(data);
  endtask

  logic [9:0] t3_pat;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[5] = 32'hA5A5_0014;
    rr_m0_req = 1'b0;
    rr_m1_req = 1'b0;
    reset = 1'b1;
    // A legal write request present during reset must be ignored.
    drv0(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0001);
    drv1(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    tick;
    mid;
    check("rst_m0_ack", 32'(m0_ack), 32'd0);
    check("rst_memwrite", 32'(dm_memwrite), 32'd0);
    check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("rst_m0_err", 32'(m0_err), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick;
    reset = 1'b0;
    drv0(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    check("rst_mem_untouched", mem[4], 32'h0000_0000);

    // T1: m0 write then read back.
    drv0(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    expect_write(32'h0000_0010, 32'hDEAD_BEEF);
    mid;
    check("t1_wr_ack", 32'(m0_ack), 32'd1);
    check("t1_wr_grant", 32'(grant_id), 32'd0);
    check("t1_wr_pc", dm_pc, 32'h0040_0010);
    tick;
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000);
    mid;
    check("t1_rd_ack", 32'(m0_ack), 32'd1);
    check("t1_wr_no_rvalid", 32'(m0_rvalid), 32'd0);
    check("t1_rd_no_write", 32'(dm_memwrite), 32'd0);
    tick;
    drv0(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    mid;
    check("t1_rvalid", 32'(m0_rvalid), 32'd1);
    check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("t1_err", 32'(m0_err), 32'd0);
    tick;
    mid;
    check("t1_rvalid_pulse", 32'(m0_rvalid), 32'd0);
    check("t1_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // T3: both request continuously in priority mode.
    t3_pat = 10'b10_0001_0000;
    tick;
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000);
    drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000);
    for (int i = 0; i < 10; i++) begin
      mid;
      check("t3_acks", {30'd0, m1_ack, m0_ack}, t3_pat[i] ? 32'd2 : 32'd1);
      tick;
    end

    // T4: legal write/read at the top word, then illegal write and read on m1.
    drv0(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    drv1(1'b1, 1'b1, 32'h0000_0FFC, 32'h1234_5678);
    expect_write(32'h0000_0FFC, 32'h1234_5678);
    mid;
    check("t4_top_ack", 32'(m1_ack), 32'd1);
    check("t4_top_grant", 32'(grant_id), 32'd1);
    check("t4_top_we", 32'(dm_memwrite), 32'd1);
    check("t4_top_pc", dm_pc, 32'h0080_0FFC);
    tick;
    drv1(1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000);
    mid;
    check("t4_top_rd_ack", 32'(m1_ack), 32'd1);
    tick;
    drv1(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0055);
    mid;
    check("t4_top_rvalid", 32'(m1_rvalid), 32'd1);
    check("t4_top_rdata", m1_rdata, 32'h1234_5678);
    check("t4_top_err", 32'(m1_err), 32'd0);
    check("t4_oor_ack", 32'(m1_ack), 32'd1);
    check("t4_oor_nowrite", 32'(dm_memwrite), 32'd0);
    tick;
    drv1(1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000);
    mid;
    check("t4_mis_ack", 32'(m1_ack), 32'd1);
    check("t4_mis_nowrite", 32'(dm_memwrite), 32'd0);
    check("t4_oor_err", 32'(m1_err), 32'd1);
    check("t4_oor_no_rvalid", 32'(m1_rvalid), 32'd0);
    tick;
    drv1(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    mid;
    check("t4_mis_err", 32'(m1_err), 32'd1);
    check("t4_mis_rvalid", 32'(m1_rvalid), 32'd1);
    check("t4_mis_rdata", m1_rdata, 32'd0);
    tick;
    mid;
    check("t4_err_pulse", 32'(m1_err), 32'd0);

    // Loser drops its request: no side effects for m1.
    tick;
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000);
    drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000);
    mid;
    check("drop_acks", {30'd0, m1_ack, m0_ack}, 32'd1);
    tick;
    drv0(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    drv1(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    mid;
    check("drop_m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("drop_m0_rvalid", 32'(m0_rvalid), 32'd1);

    // T6: m0 write followed by m1 read of the same word.
    tick;
    drv0(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005);
    expect_write(32'h0000_0020, 32'h0000_0005);
    mid;
    check("t6_wr_ack", 32'(m0_ack), 32'd1);
    tick;
    drv0(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    drv1(1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000);
    mid;
    check("t6_rd_ack", 32'(m1_ack), 32'd1);
    tick;
    drv1(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    mid;
    check("t6_rvalid", 32'(m1_rvalid), 32'd1);
    check("t6_rdata", m1_rdata, 32'h0000_0005);

    // T5: read acked, then reset in the following cycle.
    tick;
    drv0(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000);
    mid;
    check("t5_rd_ack", 32'(m0_ack), 32'd1);
    tick;
    reset = 1'b1;
    drv1(1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000);
    mid;
    check("t5_rvalid_t1", 32'(m0_rvalid), 32'd0);
    check("t5_ack_rst", {30'd0, m1_ack, m0_ack}, 32'd0);
    tick;
    mid;
    check("t5_rvalid_t2", 32'(m0_rvalid), 32'd0);
    check("t5_ack_rst2", {30'd0, m1_ack, m0_ack}, 32'd0);
    tick;
    reset = 1'b0;
    mid;
    check("t5_first_grant", {30'd0, m1_ack, m0_ack}, 32'd1);
    tick;
    drv0(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    drv1(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);

    // T2: round-robin instance, both requesting for 6 cycles.
    rr_m0_req = 1'b1;
    rr_m1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid;
      check("t2_acks", {30'd0, rr_m1_ack, rr_m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick;
    end
    rr_m0_req = 1'b0;
    rr_m1_req = 1'b0;

    tick;
    mid;
    check("sb_pending", 32'(wq_addr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
